// File: rtl/mic_i2s_rx.sv
// mic_i2s_rx - I2S microphone receiver with word-select generation and
// optional decimating accumulator.
//
// Drives WS for one or two MEMS microphones, deserialises their MSB-first
// two's-complement samples from the shared data line, and optionally averages
// 2^DEC_LOG2 frames before presenting a sample pair.
//
// Ports:
//   BCLK    in   bit clock, the only clock (rising edge)
//   RESET   in   asynchronous active-low reset
//   EN      in   run enable, sampled only when the frame counter is 0
//   D_IN    in   serial data from the microphone(s)
//   WS      out  word select: 0 = left slot, 1 = right slot (registered)
//   DATA_L  out  left output sample, signed, WIDTH bits
//   DATA_R  out  right output sample, signed, WIDTH bits (0 when STEREO=0)
//   VALID   out  one-cycle strobe marking new DATA_L/DATA_R
module mic_i2s_rx #(
  parameter int WIDTH     = 18,
  parameter int SLOT_BITS = 32,
  parameter int STEREO    = 1,
  parameter int DEC_LOG2  = 0
) (
  input  logic                    BCLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    D_IN,
  output logic                    WS,
  output logic signed [WIDTH-1:0] DATA_L,
  output logic signed [WIDTH-1:0] DATA_R,
  output logic                    VALID
);

  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam int AW = WIDTH + DEC_LOG2;
  localparam int FW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_BITS);
  localparam logic [CW-1:0] CNT_LSB  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_BITS - 1);

  localparam logic [FW-1:0] FCNT_ZERO = FW'(0);
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
  localparam logic [FW-1:0] FCNT_MAX  = FW'((1 << DEC_LOG2) - 1);

  localparam logic signed [AW-1:0]    ACC_ZERO  = AW'(0);
  localparam logic signed [WIDTH-1:0] DATA_ZERO = WIDTH'(0);
  localparam logic                    STEREO_EN = (STEREO != 32'sd0);

  logic [CW-1:0]             cnt_r;
  logic [FW-1:0]             fcnt_r;
  logic signed [WIDTH-1:0]   sh_l_r;
  logic signed [WIDTH-1:0]   sh_r_r;
  logic signed [AW-1:0]      acc_l_r;
  logic signed [AW-1:0]      acc_r_r;

  logic                      run_s;
  logic                      right_s;
  logic [CW-1:0]             bit_s;
  logic                      cap_s;
  logic                      frame_end_s;
  logic                      dec_done_s;
  logic [CW-1:0]             cnt_nxt_s;
  logic                      ws_nxt_s;
  logic signed [WIDTH-1:0]   sh_l_nxt_s;
  logic signed [WIDTH-1:0]   sh_r_nxt_s;
  logic signed [AW-1:0]      sum_l_s;
  logic signed [AW-1:0]      sum_r_s;
  logic signed [WIDTH-1:0]   avg_l_s;
  logic signed [WIDTH-1:0]   avg_r_s;

  // Next-state logic: frame counter, slot decode, capture and accumulation.
  always_comb begin
    run_s       = (cnt_r != CNT_ZERO) || EN;
    right_s     = (cnt_r >= CNT_SLOT);
    frame_end_s = (cnt_r == CNT_LAST);
    dec_done_s  = frame_end_s && (fcnt_r == FCNT_MAX);

    if (right_s) begin
      bit_s = cnt_r - CNT_SLOT;
    end else begin
      bit_s = cnt_r;
    end

    // One-bit I2S delay: slot bit 1 carries the MSB, bit WIDTH the LSB.
    cap_s = run_s && (bit_s >= CNT_ONE) && (bit_s <= CNT_LSB);

    if (!run_s || frame_end_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
    ws_nxt_s = (cnt_nxt_s >= CNT_SLOT);

    if (cap_s && !right_s) begin
      sh_l_nxt_s = {sh_l_r[WIDTH-2:0], D_IN};
    end else begin
      sh_l_nxt_s = sh_l_r;
    end

    if (cap_s && right_s && STEREO_EN) begin
      sh_r_nxt_s = {sh_r_r[WIDTH-2:0], D_IN};
    end else begin
      sh_r_nxt_s = sh_r_r;
    end

    // The shifted-in values are used so that an LSB landing on the
    // frame-end edge itself (SLOT_BITS == WIDTH+1) is still included.
    sum_l_s = acc_l_r + AW'(sh_l_nxt_s);
    sum_r_s = acc_r_r + AW'(sh_r_nxt_s);
    avg_l_s = WIDTH'(sum_l_s >>> DEC_LOG2);
    avg_r_s = WIDTH'(sum_r_s >>> DEC_LOG2);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r   <= CNT_ZERO;
      fcnt_r  <= FCNT_ZERO;
      sh_l_r  <= DATA_ZERO;
      sh_r_r  <= DATA_ZERO;
      acc_l_r <= ACC_ZERO;
      acc_r_r <= ACC_ZERO;
      WS      <= 1'b0;
      DATA_L  <= DATA_ZERO;
      DATA_R  <= DATA_ZERO;
      VALID   <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      WS     <= ws_nxt_s;
      sh_l_r <= sh_l_nxt_s;
      sh_r_r <= sh_r_nxt_s;
      VALID  <= dec_done_s;
      if (dec_done_s) begin
        DATA_L  <= avg_l_s;
        DATA_R  <= avg_r_s;
        acc_l_r <= ACC_ZERO;
        acc_r_r <= ACC_ZERO;
        fcnt_r  <= FCNT_ZERO;
      end else if (frame_end_s) begin
        acc_l_r <= sum_l_s;
        acc_r_r <= sum_r_s;
        fcnt_r  <= fcnt_r + FCNT_ONE;
      end else begin
        acc_l_r <= acc_l_r;
        acc_r_r <= acc_r_r;
        fcnt_r  <= fcnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mic_i2s_rx.sv
// tb_mic_i2s_rx - directed bench for mic_i2s_rx.
// Four receivers share BCLK/EN/D_IN: stereo raw, stereo /4, stereo /2 and
// mono raw. A frame-level model pushes expected sample pairs into one queue
// per receiver; a monitor pops them when VALID is due and checks the timing.
module tb_mic_i2s_rx;

  logic        BCLK;
  logic        RESET;
  logic        EN;
  logic        D_IN;
  logic        ws_o [4];
  logic        v_o  [4];
  logic [17:0] dl   [4];
  logic [17:0] dr   [4];

  int checks = 0;
  int errors = 0;

  int dec_a [4] = '{0, 2, 1, 0};
  int ste_a [4] = '{1, 1, 1, 0};
  int acc_l [4];
  int acc_r [4];
  int fc    [4];
  logic [35:0] sbq [4][$];

  logic        exp_v;
  logic [35:0] exp_e;

  mic_i2s_rx #(.WIDTH(18), .SLOT_BITS(32), .STEREO(1), .DEC_LOG2(0)) u0 (
    .BCLK(BCLK), .RESET(RESET), .EN(EN), .D_IN(D_IN),
    .WS(ws_o[0]), .DATA_L(dl[0]), .DATA_R(dr[0]), .VALID(v_o[0]));
  mic_i2s_rx #(.WIDTH(18), .SLOT_BITS(32), .STEREO(1), .DEC_LOG2(2)) u1 (
    .BCLK(BCLK), .RESET(RESET), .EN(EN), .D_IN(D_IN),
    .WS(ws_o[1]), .DATA_L(dl[1]), .DATA_R(dr[1]), .VALID(v_o[1]));
  mic_i2s_rx #(.WIDTH(18), .SLOT_BITS(32), .STEREO(1), .DEC_LOG2(1)) u2 (
    .BCLK(BCLK), .RESET(RESET), .EN(EN), .D_IN(D_IN),
    .WS(ws_o[2]), .DATA_L(dl[2]), .DATA_R(dr[2]), .VALID(v_o[2]));
  mic_i2s_rx #(.WIDTH(18), .SLOT_BITS(32), .STEREO(0), .DEC_LOG2(0)) u3 (
    .BCLK(BCLK), .RESET(RESET), .EN(EN), .D_IN(D_IN),
    .WS(ws_o[3]), .DATA_L(dl[3]), .DATA_R(dr[3]), .VALID(v_o[3]));

  initial BCLK = 1'b0;
  always #5 BCLK = ~BCLK;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      acc_l[i] = 0;
      acc_r[i] = 0;
      fc[i]    = 0;
      sbq[i].delete();
    end
  endtask

  // Frame-level model: sum samples, floor-divide by 2^DEC on the last frame.
  task automatic model_frame(input logic [17:0] l, input logic [17:0] r);
    int el;
    int er;
    logic [35:0] ev;
    for (int i = 0; i < 4; i++) begin
      acc_l[i] += int'($signed(l));
      if (ste_a[i] != 0) acc_r[i] += int'($signed(r));
      fc[i]++;
      if (fc[i] == (1 << dec_a[i])) begin
        el = acc_l[i] >>> dec_a[i];
        er = acc_r[i] >>> dec_a[i];
        ev = {el[17:0], er[17:0]};
        sbq[i].push_back(ev);
        acc_l[i] = 0;
        acc_r[i] = 0;
        fc[i]    = 0;
      end
    end
  endtask

  // Drive one 64-bit frame; en_drop / rst_at < 0 disable those events.
  task automatic drive_frame(input logic [17:0] l, input logic [17:0] r,
                             input int en_drop, input int rst_at);
    logic [17:0] word;
    int b;
    for (int k = 0; k < 64; k++) begin
      @(negedge BCLK);
      if (k == rst_at) begin
        RESET = 1'b0;
        EN    = 1'b0;
        #1;
        chk("rst_mid_ws", ws_o[0], 36'd0);
        chk("rst_mid_dl", dl[0], 36'd0);
        chk("rst_mid_dr", dr[0], 36'd0);
        chk("rst_mid_valid", v_o[0], 36'd0);
        model_clear();
        return;
      end
      chk($sformatf("ws_u0_k%0d", k), ws_o[0], (k >= 32) ? 36'd1 : 36'd0);
      chk($sformatf("ws_u3_k%0d", k), ws_o[3], (k >= 32) ? 36'd1 : 36'd0);
      EN   = (en_drop >= 0 && k >= en_drop) ? 1'b0 : 1'b1;
      b    = k % 32;
      word = (k < 32) ? l : r;
      D_IN = (b >= 1 && b <= 18) ? word[18-b] : 1'b1;
      if (k == 63) model_frame(l, r);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge BCLK);
      EN   = 1'b0;
      D_IN = 1'b0;
      chk("idle_ws", ws_o[0], 36'd0);
    end
  endtask

  // Scoreboard monitor: VALID must appear exactly when an entry is due.
  always @(posedge BCLK) begin
    #3;
    if (RESET === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        exp_v = (sbq[i].size() != 0);
        chk($sformatf("valid_u%0d", i), v_o[i], exp_v);
        if (exp_v) begin
          exp_e = sbq[i].pop_front();
          chk($sformatf("data_l_u%0d", i), dl[i], exp_e[35:18]);
          chk($sformatf("data_r_u%0d", i), dr[i], exp_e[17:0]);
        end
      end
    end
  end

  initial begin
    RESET = 1'b0;
    EN    = 1'b0;
    D_IN  = 1'b0;
    model_clear();
    repeat (3) @(negedge BCLK);
    #1;
    chk("rst_ws", ws_o[0], 36'd0);
    chk("rst_dl", dl[0], 36'd0);
    chk("rst_dr", dr[0], 36'd0);
    chk("rst_valid", v_o[0], 36'd0);
    @(negedge BCLK);
    RESET = 1'b1;
    gap(5);

    // Decimation: 100..400 averaged to 250 on the /4 receiver.
    drive_frame(18'd100, 18'h3FFFB, -1, -1);
    drive_frame(18'd200, 18'h00007, -1, -1);
    drive_frame(18'd300, 18'h1FFFF, -1, -1);
    drive_frame(18'd400, 18'h00000, -1, -1);
    gap(2);
    chk("dec4_dl", dl[1], 36'd250);
    chk("dec2_dl", dl[2], 36'd350);

    // Floor toward minus infinity: (-3 + -2) / 2 = -3.
    drive_frame(18'h3FFFD, 18'h0000A, -1, -1);
    drive_frame(18'h3FFFE, 18'h3FFF0, -1, -1);
    gap(2);
    chk("neg_floor_dl", dl[2], 36'h3FFFD);

    // Basic stereo.
    drive_frame(18'h2A5A5, 18'h1FFFF, -1, -1);
    gap(2);
    chk("stereo_dl", dl[0], 36'h2A5A5);
    chk("stereo_dr", dr[0], 36'h1FFFF);

    // Mono receiver ignores the right slot.
    drive_frame(18'h0ABCD, 18'h15555, -1, -1);
    gap(2);
    chk("mono_dl", dl[3], 36'h0ABCD);
    chk("mono_dr", dr[3], 36'd0);
    chk("stereo_dr2", dr[0], 36'h15555);

    // Enable drop mid-frame: frame completes, then idle.
    drive_frame(18'h01234, 18'h2BCDE, 10, -1);
    gap(80);
    chk("en_drop_dl", dl[0], 36'h01234);
    drive_frame(18'h3FFFF, 18'h00001, -1, -1);
    gap(2);
    chk("resume_dl", dl[0], 36'h3FFFF);

    // Reset at cnt=40 discards the partial frame.
    drive_frame(18'h12345, 18'h23456, -1, 40);
    @(negedge BCLK);
    RESET = 1'b1;
    drive_frame(18'h00055, 18'h3FF00, -1, -1);
    gap(2);
    chk("post_rst_dl", dl[0], 36'h00055);
    chk("post_rst_dr", dr[0], 36'h3FF00);

    gap(5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_empty_u%0d", i), 36'(sbq[i].size()), 36'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
